// File: rtl/cva6_ptw_sv32_walker_pkg.sv
// Shared Sv32 walker/TLB types: PTE layout, TLB refill word and walker states.
package cva6_ptw_sv32_walker_pkg;

    localparam int unsigned PTE_V       = 0;
    localparam int unsigned PTE_R       = 1;
    localparam int unsigned PTE_W       = 2;
    localparam int unsigned PTE_X       = 3;
    localparam int unsigned PTE_A       = 6;
    localparam int unsigned PTE_PPN_LSB = 10;

    localparam int unsigned PPN_LEN  = 22;
    localparam int unsigned VPN_LEN  = 20;
    localparam int unsigned ASID_LEN = 9;

    typedef struct packed {
        logic [PPN_LEN-1:0] ppn;
        logic [1:0]         rsw;
        logic               d;
        logic               a;
        logic               g;
        logic               u;
        logic               x;
        logic               w;
        logic               r;
        logic               v;
    } pte_t;

    // 63-bit refill word, consumed unchanged by cva6_tlb_sv32.update_i
    typedef struct packed {
        logic                valid;
        logic                is_4m;
        logic [VPN_LEN-1:0]  vpn;
        logic [ASID_LEN-1:0] asid;
        pte_t                pte;
    } tlb_update_t;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        DRAIN
    } walk_state_e;

endpackage

// File: rtl/cva6_ptw_sv32_walker_if.sv
// PTE read port: req/gnt address phase, rvalid data phase, one read outstanding.
interface cva6_ptw_sv32_walker_if #(
    parameter int unsigned PLEN = 34
);
    logic            mem_req_o;
    logic [PLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/cva6_ptw_sv32_walker_pte_check.sv
// Combinational Sv32 PTE decode for one walk level: leaf detection and fault rules.
module cva6_ptw_sv32_walker_pte_check
    import cva6_ptw_sv32_walker_pkg::*;
(
    input  logic [31:0] pte,
    input  logic        level1,
    output logic        leaf,
    output logic        fault
);
    logic v, r, w, x, a;
    logic misaligned;
    logic unused_pte_bits;

    assign v    = pte[PTE_V];
    assign r    = pte[PTE_R];
    assign w    = pte[PTE_W];
    assign x    = pte[PTE_X];
    assign a    = pte[PTE_A];
    assign leaf = r | x;

    // A level-1 leaf maps 4 MiB, so its low 10 PPN bits must be zero
    assign misaligned = level1 & leaf & (pte[PTE_PPN_LSB +: 10] != 10'd0);

    // A pointer PTE at level 0 has nowhere left to point
    assign fault = ~v | (~r & w) | (leaf & ~a) | misaligned | (~level1 & ~leaf);

    assign unused_pte_bits = ^{pte[31:20], pte[9:7], pte[5:4]};
endmodule

// File: rtl/cva6_ptw_sv32_walker.sv
// Sv32 two-level page-table walker refilling cva6_tlb_sv32; all outputs registered.
module cva6_ptw_sv32_walker
    import cva6_ptw_sv32_walker_pkg::*;
#(
    parameter int unsigned ASID_WIDTH = 9,
    parameter int unsigned PLEN       = 34
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [PPN_LEN-1:0]    satp_ppn_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    input  logic                  miss_i,
    input  logic [31:0]           miss_vaddr_i,
    output logic                  walking_o,
    cva6_ptw_sv32_walker_if.master mem,
    output tlb_update_t           update_o,
    output logic                  page_fault_o,
    output logic [31:0]           bad_vaddr_o
);
    walk_state_e           state_q, state_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [31:0]           vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  latch_miss;
    logic [PLEN-1:0]       addr_d;
    tlb_update_t           update_d;
    logic                  fault_d;
    logic [31:0]           bad_vaddr_d;
    pte_t                  rd_pte;
    logic                  pte_leaf, pte_fault;

    assign rd_pte = pte_t'(mem.mem_rdata_i);

    cva6_ptw_sv32_walker_pte_check u_sv32_pte_check (
        .pte    (mem.mem_rdata_i),
        .level1 (state_q == L1_WAIT),
        .leaf   (pte_leaf),
        .fault  (pte_fault)
    );

    // Next state plus next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        latch_miss   = 1'b0;
        addr_d       = mem.mem_addr_o;
        update_d     = '0;
        fault_d      = 1'b0;
        bad_vaddr_d  = bad_vaddr_o;

        case (state_q)
            IDLE: begin
                if (miss_i && !flush_i) begin
                    state_d    = L1_REQ;
                    latch_miss = 1'b1;
                    addr_d     = PLEN'({satp_ppn_i, miss_vaddr_i[31:22], 2'b00});
                end
            end
            L1_REQ, L0_REQ: begin
                // A flush cannot retract a pending request; remember it until gnt
                if (flush_i) flush_pend_d = 1'b1;
                if (mem.mem_gnt_i) begin
                    flush_pend_d = 1'b0;
                    if (flush_i || flush_pend_q)
                        state_d = DRAIN;
                    else
                        state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end
            L1_WAIT, L0_WAIT: begin
                if (flush_i) begin
                    state_d = mem.mem_rvalid_i ? IDLE : DRAIN;
                end else if (mem.mem_rvalid_i) begin
                    if (pte_fault) begin
                        state_d     = IDLE;
                        fault_d     = 1'b1;
                        bad_vaddr_d = vaddr_q;
                    end else if (pte_leaf) begin
                        state_d        = IDLE;
                        update_d.valid = 1'b1;
                        update_d.is_4m = (state_q == L1_WAIT);
                        update_d.vpn   = vaddr_q[31:12];
                        update_d.asid  = ASID_LEN'(asid_q);
                        update_d.pte   = rd_pte;
                    end else begin
                        state_d = L0_REQ;
                        addr_d  = PLEN'({rd_pte.ppn, vaddr_q[21:12], 2'b00});
                    end
                end
            end
            DRAIN: begin
                if (mem.mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            flush_pend_q   <= 1'b0;
            walking_o      <= 1'b0;
            mem.mem_req_o  <= 1'b0;
            mem.mem_addr_o <= '0;
            update_o       <= '0;
            page_fault_o   <= 1'b0;
            bad_vaddr_o    <= '0;
        end else begin
            state_q        <= state_d;
            flush_pend_q   <= flush_pend_d;
            walking_o      <= (state_d != IDLE);
            mem.mem_req_o  <= (state_d == L1_REQ) || (state_d == L0_REQ);
            mem.mem_addr_o <= addr_d;
            update_o       <= update_d;
            page_fault_o   <= fault_d;
            bad_vaddr_o    <= bad_vaddr_d;
        end
    end

    // Miss context captured when a walk starts; pure data, no reset needed
    always_ff @(posedge clk_i) begin
        if (latch_miss) begin
            vaddr_q <= miss_vaddr_i;
            asid_q  <= asid_i;
        end
    end
endmodule

// File: tb/tb_cva6_ptw_sv32_walker.sv
// Bench for the Sv32 walker: directed walks, flush and reset cases, randomized page tables.
module tb_cva6_ptw_sv32_walker;
    import cva6_ptw_sv32_walker_pkg::*;

    localparam logic [21:0] SATP = 22'h00100;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic        flush_i      = 1'b0;
    logic        miss_i       = 1'b0;
    logic [21:0] satp_ppn_i   = SATP;
    logic [8:0]  asid_i       = 9'd1;
    logic [31:0] miss_vaddr_i = 32'h0;
    logic        walking_o;
    tlb_update_t update_o;
    logic        page_fault_o;
    logic [31:0] bad_vaddr_o;

    cva6_ptw_sv32_walker_if #(.PLEN(34)) mif ();

    cva6_ptw_sv32_walker #(.ASID_WIDTH(9), .PLEN(34)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .satp_ppn_i   (satp_ppn_i),
        .asid_i       (asid_i),
        .miss_i       (miss_i),
        .miss_vaddr_i (miss_vaddr_i),
        .walking_o    (walking_o),
        .mem          (mif),
        .update_o     (update_o),
        .page_fault_o (page_fault_o),
        .bad_vaddr_o  (bad_vaddr_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Page-table memory; unmapped words read as zero (invalid PTE)
    logic [31:0] pt [logic [33:0]];

    function automatic logic [31:0] pt_rd(input logic [33:0] a);
        if (pt.exists(a)) return pt[a];
        return 32'h0;
    endfunction

    // Memory responder state
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          req_wait  = 0;
    int          rv_cnt    = 0;
    bit          pend      = 1'b0;
    logic [33:0] pend_addr = '0;
    logic [33:0] held_addr = '0;
    int          proto_err = 0;
    int          last_rv_cyc = 0;
    logic [33:0] req_log [$];

    initial begin
        mif.mem_gnt_i    = 1'b0;
        mif.mem_rvalid_i = 1'b0;
        mif.mem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk_i);
            #1;
            mif.mem_gnt_i    = 1'b0;
            mif.mem_rvalid_i = 1'b0;
            mif.mem_rdata_i  = $urandom;
            if (!rst_ni) begin
                pend     = 1'b0;
                req_wait = 0;
            end else begin
                if (pend) begin
                    if (rv_cnt == 0) begin
                        mif.mem_rvalid_i = 1'b1;
                        mif.mem_rdata_i  = pt_rd(pend_addr);
                        pend             = 1'b0;
                        last_rv_cyc      = cyc;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (mif.mem_req_o) begin
                    if (pend) proto_err++;
                    if (req_wait > 0 && mif.mem_addr_o !== held_addr) proto_err++;
                    held_addr = mif.mem_addr_o;
                    if (req_wait >= gnt_delay) begin
                        mif.mem_gnt_i = 1'b1;
                        req_log.push_back(mif.mem_addr_o);
                        pend      = 1'b1;
                        pend_addr = mif.mem_addr_o;
                        rv_cnt    = rv_delay;
                        req_wait  = 0;
                    end else begin
                        req_wait++;
                    end
                end else if (req_wait > 0) begin
                    proto_err++;
                    req_wait = 0;
                end
            end
        end
    end

    // Walk outcome from the Sv32 rules: up to two levels, addresses by arithmetic
    function automatic void ref_walk(input logic [31:0] va, input logic [8:0] as,
                                     input int d, input int rd,
                                     output bit flt, output logic [62:0] upd,
                                     output int lat, output int nreq);
        longint unsigned a, ppn;
        logic [31:0]     p;
        bit              v, r, w, x, acc, leaf;
        flt  = 1'b0;
        upd  = '0;
        lat  = 1;
        nreq = 0;
        a = longint'(SATP) * 4096 + longint'(va[31:22]) * 4;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            p = pt_rd(34'(a));
            nreq++;
            lat += d + rd + 2;
            v = p[0]; r = p[1]; w = p[2]; x = p[3]; acc = p[6];
            leaf = r | x;
            ppn  = longint'(p) >> 10;
            if (!v || (w && !r) || (leaf && !acc) ||
                (leaf && lvl == 1 && (ppn % 1024) != 0) || (!leaf && lvl == 0)) begin
                flt = 1'b1;
                return;
            end
            if (leaf) begin
                upd = {1'b1, (lvl == 1), va[31:12], as, p};
                return;
            end
            a = ppn * 4096 + longint'(va[21:12]) * 4;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          t_miss = 0;
    logic [62:0] last_upd;
    bit          last_flt;

    task automatic launch(input logic [31:0] va);
        @(negedge clk_i);
        miss_vaddr_i = va;
        miss_i       = 1'b1;
        t_miss       = cyc;
        @(negedge clk_i);
        miss_i = 1'b0;
    endtask

    task automatic wait_result(output logic [62:0] upd, output bit flt,
                               output int lat, output logic w);
        upd = '0; flt = 1'b0; lat = -1; w = 1'bx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (update_o.valid || page_fault_o) begin
                upd = update_o;
                flt = page_fault_o;
                lat = cyc - t_miss;
                w   = walking_o;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int wl, output bit seen);
        seen = 1'b0; wl = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (update_o.valid || page_fault_o) seen = 1'b1;
            if (!walking_o) begin
                wl = cyc;
                break;
            end
        end
    endtask

    function automatic logic [33:0] log_at(input int i);
        if (req_log.size() > i) return req_log[i];
        return '1;
    endfunction

    task automatic walk(input string tag, input logic [31:0] va, input int d, input int r);
        bit          eflt, oflt;
        logic [62:0] eupd, oupd;
        int          elat, ereq, olat;
        logic        ow;
        gnt_delay = d;
        rv_delay  = r;
        req_log.delete();
        ref_walk(va, asid_i, d, r, eflt, eupd, elat, ereq);
        launch(va);
        wait_result(oupd, oflt, olat, ow);
        check({tag, ".outcome"}, {oflt, oupd}, {eflt, eupd});
        check({tag, ".latency"}, 64'(olat), 64'(elat));
        check({tag, ".nreq"}, 64'(req_log.size()), 64'(ereq));
        check({tag, ".walking_end"}, 64'(ow), 64'(0));
        if (eflt) check({tag, ".bad_vaddr"}, 64'(bad_vaddr_o), 64'(va));
        last_upd = oupd;
        last_flt = oflt;
    endtask

    task automatic load_4k_table();
        pt.delete();
        pt[34'h100120] = 32'h00080001;
        pt[34'h200D14] = 32'h002AF04F;
    endtask

    int   wl;
    bit   seen;
    bit   found;

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        check("reset.walking", 64'(walking_o), 64'(0));
        check("reset.req", 64'(mif.mem_req_o), 64'(0));
        check("reset.addr", 64'(mif.mem_addr_o), 64'(0));
        check("reset.update", 64'(update_o), 64'(0));
        check("reset.fault", 64'(page_fault_o), 64'(0));
        check("reset.bad_vaddr", 64'(bad_vaddr_o), 64'(0));
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // 4K walk
        load_4k_table();
        walk("t1_4k", 32'h12345000, 0, 0);
        check("t1_4k.word", 64'(last_upd), 64'({1'b1, 1'b0, 20'h12345, 9'd1, 32'h002AF04F}));
        check("t1_4k.addr_l1", 64'(log_at(0)), 64'(34'h100120));
        check("t1_4k.addr_l0", 64'(log_at(1)), 64'(34'h200D14));

        // 4M walk
        pt.delete();
        pt[34'h100804] = 32'h0010004F;
        walk("t2_4m", 32'h80400000, 0, 0);
        check("t2_4m.word", 64'(last_upd), 64'({1'b1, 1'b1, 20'h80400, 9'd1, 32'h0010004F}));
        check("t2_4m.addr_l1", 64'(log_at(0)), 64'(34'h100804));

        // Misaligned superpage
        pt[34'h100804] = 32'h0010044F;
        walk("t3_misal", 32'h80400000, 0, 0);
        check("t3_misal.fault", 64'(last_flt), 64'(1));

        // Invalid L1, then non-leaf L0
        pt.delete();
        pt[34'h100120] = 32'h00080000;
        walk("t4_l1_inv", 32'h12345000, 0, 0);
        check("t4_l1_inv.fault", 64'(last_flt), 64'(1));
        pt[34'h100120] = 32'h00080001;
        pt[34'h200D14] = 32'h002AF001;
        walk("t4_l0_ptr", 32'h12345000, 0, 0);
        check("t4_l0_ptr.fault", 64'(last_flt), 64'(1));

        // Grant delayed three cycles on every request
        load_4k_table();
        walk("t5_gnt3", 32'h12345000, 3, 0);
        check("t5_gnt3.word", 64'(last_upd), 64'({1'b1, 1'b0, 20'h12345, 9'd1, 32'h002AF04F}));
        check("t5_gnt3.protocol", 64'(proto_err), 64'(0));

        // Flush while waiting for the level-0 PTE
        gnt_delay = 0; rv_delay = 2; req_log.delete();
        launch(32'h12345000);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mif.mem_req_o && mif.mem_addr_o == 34'h200D14) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check("t5_flush_l0.reach", 64'(found), 64'(1));
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        wait_idle(wl, seen);
        check("t5_flush_l0.no_result", 64'(seen), 64'(0));
        check("t5_flush_l0.drop_cycle", 64'(wl), 64'(last_rv_cyc + 1));
        check("t5_flush_l0.nreq", 64'(req_log.size()), 64'(2));

        // Flush during a level-1 request still waiting for grant
        gnt_delay = 3; rv_delay = 0; req_log.delete();
        launch(32'h12345000);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        wait_idle(wl, seen);
        check("flush_l1req.no_result", 64'(seen), 64'(0));
        check("flush_l1req.drop_cycle", 64'(wl), 64'(last_rv_cyc + 1));
        check("flush_l1req.nreq", 64'(req_log.size()), 64'(1));
        check("flush_l1req.protocol", 64'(proto_err), 64'(0));
        repeat (2) @(negedge clk_i);

        // Asynchronous reset while waiting for the level-1 PTE
        pt.delete();
        pt[34'h100804] = 32'h0010044F;
        walk("pre_rst_fault", 32'h80400000, 0, 0);
        load_4k_table();
        gnt_delay = 0; rv_delay = 3;
        launch(32'h12345000);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (walking_o && !mif.mem_req_o) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check("t6_rst.reach_l1_wait", 64'(found), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        check("t6_rst.walking", 64'(walking_o), 64'(0));
        check("t6_rst.req", 64'(mif.mem_req_o), 64'(0));
        check("t6_rst.addr", 64'(mif.mem_addr_o), 64'(0));
        check("t6_rst.update", 64'(update_o), 64'(0));
        check("t6_rst.fault", 64'(page_fault_o), 64'(0));
        check("t6_rst.bad_vaddr", 64'(bad_vaddr_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        walk("t6_after_rst", 32'h12345000, 0, 0);
        check("t6_after_rst.word", 64'(last_upd), 64'({1'b1, 1'b0, 20'h12345, 9'd1, 32'h002AF04F}));

        // Randomized page tables, ASIDs and memory timing
        for (int n = 0; n < 30; n++) begin
            logic [31:0] va, p1, p0;
            va     = $urandom;
            asid_i = 9'($urandom);
            p1     = $urandom;
            p0     = $urandom;
            if ($urandom_range(0, 3) != 0) begin p1[6] = 1'b1; p1[0] = 1'b1; end
            if ($urandom_range(0, 1) != 0) p1[3:1] = 3'b000;
            if ($urandom_range(0, 1) != 0) p1[19:10] = 10'd0;
            if ($urandom_range(0, 3) != 0) begin p0[6] = 1'b1; p0[0] = 1'b1; end
            if ($urandom_range(0, 3) == 0) p0[3:1] = 3'b000;
            pt.delete();
            pt[{SATP, va[31:22], 2'b00}]    = p1;
            pt[{p1[31:10], va[21:12], 2'b00}] = p0;
            walk("rand", va, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
        end

        check("final.protocol", 64'(proto_err), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
